// File: rtl/ex_stall_controller.sv
// ex_stall_controller
//   Central stall/flush arbiter sitting between the hazard detection unit
//   and the PC, IF/ID and ID/EX registers. It merges the load-use request
//   with the stall produced by the multi-cycle multiplier in EX, and it
//   counts stall cycles for performance analysis.
//
// Parameters
//   MULT_LATENCY  EX cycles a multiply occupies (1..7)
//   PERF_W        width of the saturating stall-cycle counter
//
// Ports
//   clk, arst         clock (rising edge), async active-high reset
//   hz_flush          load-use bubble request from hazard unit
//   hz_pc_enable      PC enable from hazard unit
//   hz_if_id_enable   IF/ID enable from hazard unit
//   mult_start_ex     valid multiply present in EX this cycle
//   pc_enable         final PC enable
//   if_id_enable      final IF/ID enable
//   id_ex_enable      ID/EX enable (0 freezes the instruction in EX)
//   id_ex_flush       bubble into ID/EX
//   ex_mem_bubble     bubble into EX/MEM (multiply result not ready)
//   mult_done         multiply result valid in EX this cycle
//   mult_busy         multiplier sequence in progress (BUSY state)
//   perf_stall_count  cycles with pc_enable==0, saturating
module ex_stall_controller #(
  parameter int MULT_LATENCY = 4,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              hz_flush,
  input  logic              hz_pc_enable,
  input  logic              hz_if_id_enable,
  input  logic              mult_start_ex,
  output logic              pc_enable,
  output logic              if_id_enable,
  output logic              id_ex_enable,
  output logic              id_ex_flush,
  output logic              ex_mem_bubble,
  output logic              mult_done,
  output logic              mult_busy,
  output logic [PERF_W-1:0] perf_stall_count
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MULT_LATENCY - 1);
  localparam bit         MULTI    = (MULT_LATENCY > 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [PERF_W-1:0] perf_q, perf_d;
  logic              start;
  logic              stall;
  logic              done;

  // Next state and the internal stall/done decisions.
  always_comb begin
    // A start seen while reset is asserted must not launch a sequence,
    // otherwise outputs would stall during reset.
    start   = (state_q == IDLE) && mult_start_ex && !arst;
    stall   = 1'b0;
    done    = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (MULTI) begin
            stall   = 1'b1;
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            // Single-cycle multiply: result ready immediately, no stall.
            done = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q > 3'd1) begin
          // Same instruction still held in EX; hazard inputs and new
          // starts are ignored until the done cycle.
          stall = 1'b1;
          cnt_d = cnt_q - 3'd1;
        end else begin
          // cnt==1 is the done cycle; cnt==0 cannot occur but recovers.
          done    = (cnt_q == 3'd1);
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // While stalling, ID/EX is frozen so a hazard flush must not clobber it.
  always_comb begin
    pc_enable     = stall ? 1'b0 : hz_pc_enable;
    if_id_enable  = stall ? 1'b0 : hz_if_id_enable;
    id_ex_flush   = stall ? 1'b0 : hz_flush;
    id_ex_enable  = !stall;
    ex_mem_bubble = stall;
    mult_done     = done;
    mult_busy     = (state_q == BUSY);
  end

  // Saturating counter: holds at all-ones rather than wrapping.
  always_comb begin
    perf_d = perf_q;
    if (!pc_enable && (perf_q != '1)) perf_d = perf_q + PERF_W'(1);
  end

  assign perf_stall_count = perf_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

endmodule

// File: tb/tb_ex_stall_controller.sv
// Scoreboard bench for ex_stall_controller. Instance A uses
// MULT_LATENCY=4/PERF_W=32, instance B MULT_LATENCY=1/PERF_W=2; both share
// the input wires. Each directed vector carries hand-computed outputs that
// are queued when the vector is driven; the monitor pops one entry on each
// falling edge and compares it against the selected instance.
module tb_ex_stall_controller;

  logic clk = 1'b0;
  logic arst, hz_flush, hz_pc_enable, hz_if_id_enable, mult_start_ex;

  logic a_pc, a_ifid, a_idex_en, a_idex_fl, a_bub, a_done, a_busy;
  logic [31:0] a_perf;
  logic b_pc, b_ifid, b_idex_en, b_idex_fl, b_bub, b_done, b_busy;
  logic [1:0]  b_perf;

  always #5 clk = ~clk;

  ex_stall_controller #(.MULT_LATENCY(4), .PERF_W(32)) dut_a (
    .clk(clk), .arst(arst), .hz_flush(hz_flush), .hz_pc_enable(hz_pc_enable),
    .hz_if_id_enable(hz_if_id_enable), .mult_start_ex(mult_start_ex),
    .pc_enable(a_pc), .if_id_enable(a_ifid), .id_ex_enable(a_idex_en),
    .id_ex_flush(a_idex_fl), .ex_mem_bubble(a_bub), .mult_done(a_done),
    .mult_busy(a_busy), .perf_stall_count(a_perf)
  );

  ex_stall_controller #(.MULT_LATENCY(1), .PERF_W(2)) dut_b (
    .clk(clk), .arst(arst), .hz_flush(hz_flush), .hz_pc_enable(hz_pc_enable),
    .hz_if_id_enable(hz_if_id_enable), .mult_start_ex(mult_start_ex),
    .pc_enable(b_pc), .if_id_enable(b_ifid), .id_ex_enable(b_idex_en),
    .id_ex_flush(b_idex_fl), .ex_mem_bubble(b_bub), .mult_done(b_done),
    .mult_busy(b_busy), .perf_stall_count(b_perf)
  );

  typedef struct {
    bit         dut;
    logic [6:0] outs;   // {pc, if_id, id_ex_en, id_ex_flush, bubble, done, busy}
    int         perf;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   vec_id = 0;

  // Input encoding {arst, hz_flush, hz_pc_enable, hz_if_id_enable, mult_start_ex}
  localparam logic [6:0] PASS  = 7'b1110000;  // idle, hazards allow flow
  localparam logic [6:0] STRT  = 7'b0000100;  // start cycle (still IDLE)
  localparam logic [6:0] STALL = 7'b0000101;  // BUSY stall cycle
  localparam logic [6:0] DONE  = 7'b1110011;  // done cycle, hazards allow flow
  localparam logic [6:0] LU    = 7'b0011000;  // idle load-use pass-through
  localparam logic [6:0] LUDN  = 7'b0011011;  // done cycle with load-use

  task automatic step(input bit d, input logic [4:0] in, input logic [6:0] e,
                      input int p);
    exp_t x;
    @(posedge clk);
    #1;
    {arst, hz_flush, hz_pc_enable, hz_if_id_enable, mult_start_ex} = in;
    x.dut = d; x.outs = e; x.perf = p; x.id = vec_id;
    vec_id++;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t x;
      logic [6:0] act;
      int ap;
      x = sb.pop_front();
      if (x.dut) begin
        act = {b_pc, b_ifid, b_idex_en, b_idex_fl, b_bub, b_done, b_busy};
        ap  = int'(b_perf);
      end else begin
        act = {a_pc, a_ifid, a_idex_en, a_idex_fl, a_bub, a_done, a_busy};
        ap  = int'(a_perf);
      end
      checks++;
      if (act === x.outs && ap == x.perf) passed++;
      else $display("FAIL vec%0d dut%s outs=%b want=%b perf=%0d want=%0d",
                    x.id, x.dut ? "B" : "A", act, x.outs, ap, x.perf);
    end
  end

  initial begin
    {arst, hz_flush, hz_pc_enable, hz_if_id_enable, mult_start_ex} = 5'b10111;

    // Reset with a start request present: start ignored, hazards pass.
    step(0, 5'b10111, PASS, 0);
    step(0, 5'b11001, 7'b0011000, 0);
    step(0, 5'b00110, PASS, 0);

    // Single multiply, 3 stall cycles.
    step(0, 5'b00111, STRT,  0);
    step(0, 5'b00110, STALL, 1);
    step(0, 5'b00110, STALL, 2);
    step(0, 5'b00110, DONE,  3);
    step(0, 5'b00110, PASS,  3);

    // Load-use during BUSY is suppressed, honoured in the done cycle.
    step(0, 5'b00111, STRT,  3);
    step(0, 5'b01000, STALL, 4);
    step(0, 5'b00111, STALL, 5);   // start while BUSY is ignored
    step(0, 5'b01000, LUDN,  6);

    // Back-to-back: second multiply right after the done cycle.
    step(0, 5'b00111, STRT,  7);
    step(0, 5'b00110, STALL, 8);
    step(0, 5'b00110, STALL, 9);
    step(0, 5'b00110, DONE,  10);
    step(0, 5'b00110, PASS,  10);

    // Plain load-use stall in IDLE still counts.
    step(0, 5'b01000, LU,    10);
    step(0, 5'b00110, PASS,  11);

    // Reset mid-sequence: busy drops at once, no done, counter cleared.
    step(0, 5'b00111, STRT,  11);
    step(0, 5'b10110, PASS,  0);
    step(0, 5'b00110, PASS,  0);
    step(0, 5'b00110, PASS,  0);
    step(0, 5'b00110, PASS,  0);

    // Instance B: single-cycle multiply and 2-bit saturation.
    step(1, 5'b10110, PASS,  0);
    step(1, 5'b00111, 7'b1110010, 0);
    step(1, 5'b00110, PASS,  0);
    step(1, 5'b01000, LU,    0);
    step(1, 5'b01000, LU,    1);
    step(1, 5'b01000, LU,    2);
    step(1, 5'b01000, LU,    3);
    step(1, 5'b01000, LU,    3);
    step(1, 5'b00110, PASS,  3);
    step(1, 5'b01001, 7'b0011010, 3);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
